// File: rtl/fclassify_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fclassify_pkg
// Description : Shared types and constants for the pipelined FCLASS unit:
//               format encodings, FCLASS mask bit indices, the per-operand
//               classification flag bundle and the mask encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package fclassify_pkg;

  // Operand format code carried alongside the raw operand.
  typedef enum logic [1:0] {
    FMT_S = 2'b00,
    FMT_D = 2'b01,
    FMT_H = 2'b10,
    FMT_Q = 2'b11
  } fmt_e;

  // Bit positions inside the 10-bit FCLASS result mask.
  localparam int CLS_NINF  = 0;
  localparam int CLS_NNORM = 1;
  localparam int CLS_NSUB  = 2;
  localparam int CLS_NZERO = 3;
  localparam int CLS_PZERO = 4;
  localparam int CLS_PSUB  = 5;
  localparam int CLS_PNORM = 6;
  localparam int CLS_PINF  = 7;
  localparam int CLS_SNAN  = 8;
  localparam int CLS_QNAN  = 9;

  // Classification flags held in the first pipeline stage. A value with
  // none of nan/inf/zero/subnorm set is a normal number.
  typedef struct packed {
    logic s;
    logic nan;
    logic snan;
    logic subnorm;
    logic zero;
    logic inf;
    logic illegal;
  } fclass_flags_t;

  // One-hot FCLASS mask from the flag bundle; an illegal format yields zero.
  function automatic logic [9:0] f_class_mask(input fclass_flags_t f);
    logic [9:0] m;
    m = '0;
    if (f.illegal) begin
      m = '0;
    end else if (f.nan) begin
      m[f.snan ? CLS_SNAN : CLS_QNAN] = 1'b1;
    end else if (f.inf) begin
      m[f.s ? CLS_NINF : CLS_PINF] = 1'b1;
    end else if (f.zero) begin
      m[f.s ? CLS_NZERO : CLS_PZERO] = 1'b1;
    end else if (f.subnorm) begin
      m[f.s ? CLS_NSUB : CLS_PSUB] = 1'b1;
    end else begin
      m[f.s ? CLS_NNORM : CLS_PNORM] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fclassify_if.sv
`default_nettype none
// ============================================================================
// Module      : fclassify_if
// Description : Operand/result handshake bundle for fclassify_pipe.
//               Input side : InValid/InReady, X, Fmt
//               Output side: OutValid/OutReady, ClassRes, FmtIllegal
//               Accumulator: ClassAcc (sticky class OR), ClassAccClr
//               slave  modport - the classifier
//               master modport - the operand source / result sink
// Revision    : 1.0 - initial release
// ============================================================================
interface fclassify_if
  import fclassify_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int FLEN = 64
);
  logic            InValid;
  logic            InReady;
  logic [FLEN-1:0] X;
  fmt_e            Fmt;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] ClassRes;
  logic            FmtIllegal;
  logic [9:0]      ClassAcc;
  logic            ClassAccClr;

  modport slave (
    input  InValid, X, Fmt, OutReady, ClassAccClr,
    output InReady, OutValid, ClassRes, FmtIllegal, ClassAcc
  );

  modport master (
    output InValid, X, Fmt, OutReady, ClassAccClr,
    input  InReady, OutValid, ClassRes, FmtIllegal, ClassAcc
  );
endinterface
`default_nettype wire

// File: rtl/fclassify_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fclassify_unpack
// Description : Combinational front end of the classifier. Checks that the
//               requested format is enabled, verifies NaN-boxing for formats
//               narrower than FLEN, splits sign/exponent/fraction and reduces
//               them to a classification flag bundle.
// Ports       : i_x     - raw FLEN-bit operand
//               i_fmt   - operand format code
//               o_flags - classification flags (illegal set for a disabled
//                         format, nan set for a broken NaN-box)
// Revision    : 1.0 - initial release
// ============================================================================
module fclassify_unpack
  import fclassify_pkg::*;
#(
  parameter int FLEN = 64,
  parameter int HEN  = 1,
  parameter int DEN  = 1,
  parameter int QEN  = 0
) (
  input  wire logic [FLEN-1:0] i_x,
  input  fmt_e                 i_fmt,
  output fclass_flags_t        o_flags
);

  localparam bit c_en_h = (HEN != 0) && (FLEN >= 16);
  localparam bit c_en_d = (DEN != 0) && (FLEN >= 64);
  localparam bit c_en_q = (QEN != 0) && (FLEN >= 128);

  // Bits [FLEN-1:w] of the operand, i.e. the region that must be all ones
  // for a correctly NaN-boxed w-bit value. Empty when w >= FLEN.
  function automatic logic [127:0] f_box_mask(input int w);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++) begin
      if ((i >= w) && (i < FLEN)) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [127:0] c_box_h = f_box_mask(16);
  localparam logic [127:0] c_box_s = f_box_mask(32);
  localparam logic [127:0] c_box_d = f_box_mask(64);

  // Operand zero-padded to the widest format so every field slice is legal
  // regardless of FLEN.
  logic [127:0] w_x;

  if (FLEN < 128) begin : g_pad_narrow
    assign w_x = {{(128-FLEN){1'b0}}, i_x};
  end else begin : g_pad_full
    assign w_x = i_x;
  end

  logic w_box_ok_h;
  logic w_box_ok_s;
  logic w_box_ok_d;

  assign w_box_ok_h = ((w_x & c_box_h) == c_box_h);
  assign w_box_ok_s = ((w_x & c_box_s) == c_box_s);
  assign w_box_ok_d = ((w_x & c_box_d) == c_box_d);

  logic w_en;
  logic w_box_ok;
  logic w_sign;
  logic w_exp_ones;
  logic w_exp_zero;
  logic w_frac_zero;
  logic w_frac_msb;

  always_comb begin
    w_en        = 1'b0;
    w_box_ok    = 1'b1;
    w_sign      = 1'b0;
    w_exp_ones  = 1'b0;
    w_exp_zero  = 1'b0;
    w_frac_zero = 1'b0;
    w_frac_msb  = 1'b0;
    case (i_fmt)
      FMT_S: begin
        w_en        = 1'b1;
        w_box_ok    = w_box_ok_s;
        w_sign      = w_x[31];
        w_exp_ones  = &w_x[30:23];
        w_exp_zero  = ~|w_x[30:23];
        w_frac_zero = ~|w_x[22:0];
        w_frac_msb  = w_x[22];
      end
      FMT_D: begin
        w_en        = c_en_d;
        w_box_ok    = w_box_ok_d;
        w_sign      = w_x[63];
        w_exp_ones  = &w_x[62:52];
        w_exp_zero  = ~|w_x[62:52];
        w_frac_zero = ~|w_x[51:0];
        w_frac_msb  = w_x[51];
      end
      FMT_H: begin
        w_en        = c_en_h;
        w_box_ok    = w_box_ok_h;
        w_sign      = w_x[15];
        w_exp_ones  = &w_x[14:10];
        w_exp_zero  = ~|w_x[14:10];
        w_frac_zero = ~|w_x[9:0];
        w_frac_msb  = w_x[9];
      end
      FMT_Q: begin
        w_en        = c_en_q;
        w_box_ok    = 1'b1;
        w_sign      = w_x[127];
        w_exp_ones  = &w_x[126:112];
        w_exp_zero  = ~|w_x[126:112];
        w_frac_zero = ~|w_x[111:0];
        w_frac_msb  = w_x[111];
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    o_flags = '0;
    if (!w_en) begin
      o_flags.illegal = 1'b1;
    end else if (!w_box_ok) begin
      // Improperly boxed narrow value reads as the canonical quiet NaN,
      // whose sign is positive.
      o_flags.nan = 1'b1;
    end else begin
      o_flags.s = w_sign;
      if (w_exp_ones) begin
        if (w_frac_zero) begin
          o_flags.inf = 1'b1;
        end else begin
          o_flags.nan  = 1'b1;
          o_flags.snan = ~w_frac_msb;
        end
      end else if (w_exp_zero) begin
        if (w_frac_zero) o_flags.zero    = 1'b1;
        else             o_flags.subnorm = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fclassify_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fclassify_pipe
// Description : Two-stage valid/ready pipelined RISC-V FCLASS unit with a
//               sticky class accumulator.
//               Stage 1 holds the classification flags, stage 2 holds the
//               encoded mask and the illegal-format flag.
// Ports       : clk     - clock
//               reset_n - asynchronous active-low reset
//               bus     - fclassify_if.slave: operand in (InValid/InReady,
//                         X, Fmt), result out (OutValid/OutReady, ClassRes,
//                         FmtIllegal), ClassAcc and its clear ClassAccClr
// Revision    : 1.0 - initial release
// ============================================================================
module fclassify_pipe
  import fclassify_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int FLEN = 64,
  parameter int HEN  = 1,
  parameter int DEN  = 1,
  parameter int QEN  = 0
) (
  input wire logic    clk,
  input wire logic    reset_n,
  fclassify_if.slave  bus
);

  fclass_flags_t w_flags;

  fclassify_unpack #(
    .FLEN (FLEN),
    .HEN  (HEN),
    .DEN  (DEN),
    .QEN  (QEN)
  ) u_unpack (
    .i_x     (bus.X),
    .i_fmt   (bus.Fmt),
    .o_flags (w_flags)
  );

  logic          r_v1;
  fclass_flags_t r_f1;
  logic          r_v2;
  logic [9:0]    r_class;
  logic          r_illegal;
  logic [9:0]    r_acc;

  logic       w_ready1;
  logic       w_ready2;
  logic       w_xfer;
  logic [9:0] w_mask;

  // Backpressure propagates combinationally so a full pipeline can still
  // accept a new operand in the same cycle the result leaves.
  assign w_ready2 = ~r_v2 | bus.OutReady;
  assign w_ready1 = ~r_v1 | w_ready2;
  assign w_xfer   = r_v2 & bus.OutReady;
  assign w_mask   = f_class_mask(r_f1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_f1 <= '0;
    end else if (w_ready1) begin
      r_v1 <= bus.InValid;
      if (bus.InValid) r_f1 <= w_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v2      <= 1'b0;
      r_class   <= '0;
      r_illegal <= 1'b0;
    end else if (w_ready2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_class   <= w_mask;
        r_illegal <= r_f1.illegal;
      end
    end
  end

  // Clear wins over accumulation but still captures a simultaneous
  // delivery, so no delivered class is ever lost. An illegal-format result
  // carries a zero mask and therefore leaves the accumulator untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (bus.ClassAccClr) begin
      r_acc <= w_xfer ? r_class : 10'd0;
    end else if (w_xfer) begin
      r_acc <= r_acc | r_class;
    end
  end

  assign bus.InReady    = w_ready1;
  assign bus.OutValid   = r_v2;
  assign bus.ClassRes   = XLEN'(r_class);
  assign bus.FmtIllegal = r_illegal;
  assign bus.ClassAcc   = r_acc;

endmodule
`default_nettype wire
